urv_mem_arbiter: RTL and testbench

Shares a single memory bus port between the fetch stage (instruction reads) and the execute/writeback load-store path (data reads and writes). It targets uRV configurations with one unified memory. Data accesses have priority, with a bounded-starvation guarantee for fetch. The block sits between the core pipeline and the external memory port and sequences one outstanding transaction at a time.

---
 rtl/urv_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_urv_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_mem_arbiter.sv
// urv_mem_arbiter
//
// Shares one memory bus port between instruction fetch and the load/store
// path. One transaction is outstanding at a time. Data accesses win
// arbitration. A fetch that has been held off for g_max_data_burst
// consecutive data grants is forced through next.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   im_rd_i/im_addr_i      fetch request (level) and address
//   im_kill_i              discard the in-flight fetch result
//   im_data_o/im_valid_o   fetched word and one-cycle completion pulse
//   dm_load_i/dm_store_i   data request (level, mutually exclusive)
//   dm_addr_i/dm_data_s_i  data address and store data
//   dm_data_select_i       byte enables
//   dm_data_l_o            load data, valid with dm_load_done_o
//   dm_load_done_o         one-cycle load completion pulse
//   dm_store_done_o        one-cycle store completion pulse
//   mem_*                  external bus: req held until ack, ack carries rdata
//   err_o                  one-cycle ack-timeout pulse
//
// Build option: define URV_MEM_ARB_TIMEOUT_EN to add an ack watchdog that
// aborts a BUSY transaction after g_timeout cycles. The aborted requester
// gets its completion pulse with data 0 and err_o pulses alongside it.
// Without the macro BUSY waits for ack indefinitely and err_o is 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sample and arbitrate requests, register the winner onto mem_*
// BUSY  | mem_* held, waiting for mem_ack_i (or watchdog expiry)
// DONE  | completion pulse for the served requester, requests ignored

module urv_mem_arbiter #(
    parameter int unsigned g_max_data_burst = 4,
    parameter int unsigned g_timeout        = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        im_rd_i,
    input  logic [31:0] im_addr_i,
    input  logic        im_kill_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,

    input  logic        dm_load_i,
    input  logic        dm_store_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_sel_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,

    output logic        err_o
);

    if (g_max_data_burst < 1 || g_max_data_burst > 15) begin : g_bad_burst
        $error("urv_mem_arbiter: g_max_data_burst must be 1..15");
    end
    if (g_timeout < 1 || g_timeout > 255) begin : g_bad_timeout
        $error("urv_mem_arbiter: g_timeout must be 1..255");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic [1:0] {SRV_NONE, SRV_FETCH, SRV_LOAD, SRV_STORE} srv_t;

    localparam logic [3:0] BURST_MAX = 4'(g_max_data_burst);

    state_t      state_q, state_d;
    srv_t        srv_q, srv_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_sel_q, mem_sel_d;
    logic [31:0] im_data_q, im_data_d;
    logic [31:0] dm_data_q, dm_data_d;
    logic [3:0]  burst_q, burst_d;
    logic        kill_q, kill_d;

    logic        data_req;
    logic        fetch_forced;
    logic        grant_data;
    logic        grant_fetch;
    logic        abort;

`ifdef URV_MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(g_timeout - 1);

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       timed_out_q;

    // Only IDLE leads into BUSY, so clearing outside BUSY gives a fresh
    // count on every entry.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    assign abort = (state_q == ST_BUSY) && !mem_ack_i && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            // The last BUSY cycle decides; DONE sees the result.
            if (state_q == ST_BUSY) begin
                timed_out_q <= abort;
            end
        end
    end

    assign err_o = (state_q == ST_DONE) && timed_out_q;
`else
    assign abort = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        srv_d       = srv_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        im_data_d   = im_data_q;
        dm_data_d   = dm_data_q;
        burst_d     = burst_q;
        kill_d      = kill_q;

        data_req     = dm_load_i | dm_store_i;
        fetch_forced = im_rd_i && (burst_q == BURST_MAX);
        grant_data   = 1'b0;
        grant_fetch  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (data_req && !fetch_forced) begin
                    grant_data = 1'b1;
                end else if (im_rd_i) begin
                    grant_fetch = 1'b1;
                end

                // Counts data grants that overtook a waiting fetch.
                if (!im_rd_i || grant_fetch) begin
                    burst_d = '0;
                end else if (grant_data) begin
                    burst_d = burst_q + 4'd1;
                end

                if (grant_data) begin
                    state_d     = ST_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_store_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_data_s_i;
                    mem_sel_d   = dm_data_select_i;
                    srv_d       = dm_store_i ? SRV_STORE : SRV_LOAD;
                end else if (grant_fetch) begin
                    state_d    = ST_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = im_addr_i;
                    mem_sel_d  = 4'hF;
                    srv_d      = SRV_FETCH;
                end
            end

            ST_BUSY: begin
                if (im_kill_i) begin
                    kill_d = 1'b1;
                end
                if (mem_ack_i || abort) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (srv_q == SRV_FETCH) begin
                        im_data_d = mem_ack_i ? mem_rdata_i : 32'h0;
                    end
                    if (srv_q == SRV_LOAD) begin
                        dm_data_d = mem_ack_i ? mem_rdata_i : 32'h0;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            srv_q       <= SRV_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
            im_data_q   <= '0;
            dm_data_q   <= '0;
            burst_q     <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            srv_q       <= srv_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            im_data_q   <= im_data_d;
            dm_data_q   <= dm_data_d;
            burst_q     <= burst_d;
            kill_q      <= kill_d;
        end
    end

    // A kill arriving in the DONE cycle itself must still suppress the pulse.
    assign im_valid_o      = (state_q == ST_DONE) && (srv_q == SRV_FETCH) && !kill_q && !im_kill_i;
    assign dm_load_done_o  = (state_q == ST_DONE) && (srv_q == SRV_LOAD);
    assign dm_store_done_o = (state_q == ST_DONE) && (srv_q == SRV_STORE);

    assign im_data_o   = im_data_q;
    assign dm_data_l_o = dm_data_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_sel_o   = mem_sel_q;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
module tb_urv_mem_arbiter;

    localparam int MAXB = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        im_rd_i = 1'b0;
    logic [31:0] im_addr_i = '0;
    logic        im_kill_i = 1'b0;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic        dm_load_i = 1'b0;
    logic        dm_store_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_data_s_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_sel_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        err_o;

    always #5 clk = ~clk;

    urv_mem_arbiter #(.g_max_data_burst(MAXB), .g_timeout(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .im_rd_i(im_rd_i), .im_addr_i(im_addr_i), .im_kill_i(im_kill_i),
        .im_data_o(im_data_o), .im_valid_o(im_valid_o),
        .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_addr_i(dm_addr_i),
        .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    // gnt: 0 nothing, 1 fetch, 2 load, 3 store
    typedef struct {
        bit          f, l, s;
        logic [31:0] ia, da, wd, rd;
        logic [3:0]  sel;
        int          dly, kill_at;
        bit          kill_idle, kill_done;
        int          gnt;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_ld = '0;
    int          bcnt = 0;
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit f, l, s, input logic [31:0] ia, da, wd,
                                input logic [3:0] sel, input logic [31:0] rd,
                                input int dly, kill_at, input bit kill_idle, input int gnt);
        vec_t v;
        v.f = f; v.l = l; v.s = s; v.ia = ia; v.da = da; v.wd = wd; v.sel = sel;
        v.rd = rd; v.dly = dly; v.kill_at = kill_at; v.kill_idle = kill_idle;
        v.kill_done = 1'b0; v.gnt = gnt;
        return v;
    endfunction

    // Starts at an IDLE negedge, ends at the following IDLE negedge.
    task automatic run_round(input vec_t v);
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic        e_we;
        bit          killed;
        im_rd_i = v.f; dm_load_i = v.l; dm_store_i = v.s;
        im_addr_i = v.ia; dm_addr_i = v.da; dm_data_s_i = v.wd;
        dm_data_select_i = v.sel; im_kill_i = v.kill_idle;
        @(negedge clk);
        if (v.gnt == 0) begin
            chk("idle_no_req", 32'(mem_req_o), 32'd1 - 32'd1);
            im_kill_i = 1'b0;
            return;
        end
        if (v.gnt == 1) begin
            e_addr = v.ia; e_sel = 4'hF; e_we = 1'b0;
        end else begin
            e_addr = v.da; e_sel = v.sel; e_we = (v.gnt == 3);
        end
        for (int i = 0; i <= v.dly; i++) begin
            chk("busy_req", 32'(mem_req_o), 32'd1);
            chk("busy_addr", mem_addr_o, e_addr);
            chk("busy_sel", 32'(mem_sel_o), 32'(e_sel));
            chk("busy_we", 32'(mem_we_o), 32'(e_we));
            if (v.gnt == 3) chk("busy_wdata", mem_wdata_o, v.wd);
            im_kill_i   = (i == v.kill_at);
            mem_ack_i   = (i == v.dly);
            mem_rdata_i = (i == v.dly) ? v.rd : $urandom;
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        im_kill_i = v.kill_done;
        #1;
        killed = (v.kill_at >= 0) || v.kill_done;
        if (v.gnt == 2) last_ld = v.rd;
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_im_valid", 32'(im_valid_o), 32'(v.gnt == 1 && !killed));
        chk("done_load", 32'(dm_load_done_o), 32'(v.gnt == 2));
        chk("done_store", 32'(dm_store_done_o), 32'(v.gnt == 3));
        chk("done_err", 32'(err_o), 32'd0);
        chk("done_dm_data", dm_data_l_o, last_ld);
        if (v.gnt == 1 && !killed) chk("done_im_data", im_data_o, v.rd);
        im_kill_i = 1'b0;
        @(negedge clk);
        chk("idle_pulses", 32'({im_valid_o, dm_load_done_o, dm_store_done_o}), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_we"}, 32'(mem_we_o), 32'd0);
        chk({tag, "_sel"}, 32'(mem_sel_o), 32'd0);
        chk({tag, "_addr"}, mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_pulses"}, 32'({im_valid_o, dm_load_done_o, dm_store_done_o, err_o}), 32'd0);
        chk({tag, "_im_data"}, im_data_o, 32'd0);
        chk({tag, "_dm_data"}, dm_data_l_o, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   dt;

        // Directed table; burst counter assumed 0 at start.
        tbl.push_back(mk(1, 0, 0, 32'h100, 0, 0, 4'h0, 32'h13, 1, -1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'h2000, 32'hDEADBEEF, 4'b0011, 32'h0, 2, -1, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 32'h3004, 0, 4'hF, 32'hCAFEF00D, 0, -1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, -1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h104, 0, 0, 4'h0, 32'h00A00093, 0, -1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'h40, 32'h12345678, 4'b1100, 0, 3, -1, 0, 3));
        // fetch held high against continuous loads: L,L,L,L,F,L
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 1, 0, 32'h200, 32'h500 + 32'(4 * i), 0, 4'hF,
                             32'h1000 + 32'(i), 0, -1, 0, (i == 4) ? 1 : 2));
        tbl.push_back(mk(0, 1, 0, 0, 32'h600, 0, 4'b0101, 32'h55AA, 1, -1, 0, 2));
        tbl.push_back(mk(1, 0, 1, 32'h204, 32'h700, 32'hA5A5A5A5, 4'b1000, 0, 0, -1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 32'h208, 0, 0, 4'h0, 32'h77, 2, -1, 0, 1));

        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        chk_reset_state("reset");

        foreach (tbl[i]) run_round(tbl[i]);

        // Kill in BUSY with ack after 5 cycles, then a normal fetch.
        run_round(mk(1, 0, 0, 32'h300, 0, 0, 4'h0, 32'hBAD0BAD0, 4, 1, 0, 1));
        run_round(mk(1, 0, 0, 32'h304, 0, 0, 4'h0, 32'h00000013, 0, -1, 0, 1));
        // Kill arriving in the DONE cycle.
        v = mk(1, 0, 0, 32'h308, 0, 0, 4'h0, 32'h1234, 1, -1, 0, 1);
        v.kill_done = 1'b1;
        run_round(v);
        run_round(mk(1, 0, 0, 32'h30C, 0, 0, 4'h0, 32'h4321, 0, -1, 0, 1));

        // Reset in the middle of BUSY.
        im_rd_i = 1'b0; dm_load_i = 1'b1; dm_addr_i = 32'h900; dm_data_select_i = 4'hF;
        @(negedge clk);
        chk("rst_busy_req", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1; dm_load_i = 1'b0;
        @(negedge clk);
        chk_reset_state("rst_mid");
        rst_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
        @(negedge clk);
        mem_ack_i = 1'b0;
        chk("rst_after_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        chk("rst_after_pulses", 32'({im_valid_o, dm_load_done_o, dm_store_done_o}), 32'd0);
        chk("rst_after_dm_data", dm_data_l_o, 32'd0);
        last_ld = '0;
        bcnt = 0;

        // Randomized rounds against a transaction-level priority model.
        for (int n = 0; n < 300; n++) begin
            v.f  = ($urandom_range(0, 3) != 0);
            dt   = $urandom_range(0, 2);
            v.l  = (dt == 1);
            v.s  = (dt == 2);
            v.ia = $urandom; v.da = $urandom; v.wd = $urandom; v.rd = $urandom;
            v.sel = 4'($urandom_range(0, 15));
            v.dly = $urandom_range(0, 3);
            v.kill_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, v.dly) : -1;
            v.kill_idle = ($urandom_range(0, 3) == 0);
            v.kill_done = ($urandom_range(0, 7) == 0);
            if (!v.f) begin
                bcnt  = 0;
                v.gnt = (dt == 0) ? 0 : ((dt == 1) ? 2 : 3);
            end else if (dt != 0 && bcnt < MAXB) begin
                bcnt++;
                v.gnt = (dt == 1) ? 2 : 3;
            end else begin
                bcnt  = 0;
                v.gnt = 1;
            end
            run_round(v);
        end
        im_rd_i = 1'b0; dm_load_i = 1'b0; dm_store_i = 1'b0;

`ifdef URV_MEM_ARB_TIMEOUT_EN
        // Load never acked: aborted after TMO BUSY cycles.
        dm_load_i = 1'b1; dm_addr_i = 32'hA00; dm_data_select_i = 4'hF;
        @(negedge clk);
        for (int j = 1; j <= TMO; j++) begin
            chk("tmo_req_held", 32'(mem_req_o), 32'd1);
            if (j == TMO) dm_load_i = 1'b0;
            @(negedge clk);
        end
        chk("tmo_req_drop", 32'(mem_req_o), 32'd0);
        chk("tmo_load_done", 32'(dm_load_done_o), 32'd1);
        chk("tmo_dm_data", dm_data_l_o, 32'd0);
        chk("tmo_err", 32'(err_o), 32'd1);
        @(negedge clk);
        chk("tmo_err_clear", 32'(err_o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
